// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS control FSM with a memory handshake and an iterative-multiply wait.
module multicycle_controller #(
    parameter int MULT_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] instOpcode,
    input  logic [5:0] instFunc,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       branchNe,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memToReg,
    output logic       link,
    output logic       ALUSrcA,
    output logic [1:0] regDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] pcSrc,
    output logic [1:0] regWriteDataSrc,
    output logic       multStart,
    output logic       multLoad,
    output logic       illegalInst,
    output logic [3:0] state
);
    localparam int CNT_W = $clog2(MULT_LATENCY + 1);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
        S_IEXEC = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
        S_MULT = 4'd12, S_HILOWB = 4'd13, S_LUIWB = 4'd14
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_MULT = 6'b011000;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_JR = 6'b001000;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_target;
    logic             w_legal;
    logic             w_jal;
    logic             w_unused;

    assign w_unused = zero;
    assign w_jal    = (instOpcode == OP_JAL);
    assign state    = rst ? 4'd0 : r_state;

    always_comb begin
        w_target = S_FETCH;
        w_legal  = 1'b1;
        case (instOpcode)
            OP_R: case (instFunc)
                F_ADD, F_SUB, F_AND, F_OR, F_SLT: w_target = S_REXEC;
                F_MULT:                           w_target = S_MULT;
                F_MFHI, F_MFLO:                   w_target = S_HILOWB;
                F_JR:                             w_target = S_JUMP;
                default:                          w_legal  = 1'b0;
            endcase
            OP_LW, OP_SW:            w_target = S_MEMADR;
            OP_ADDI, OP_ANDI, OP_ORI: w_target = S_IEXEC;
            OP_BEQ, OP_BNE:          w_target = S_BRANCH;
            OP_J, OP_JAL:            w_target = S_JUMP;
            OP_LUI:                  w_target = S_LUIWB;
            default:                 w_legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= memReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    r_state <= w_target;
                    if (w_target == S_MULT) r_cnt <= CNT_W'(MULT_LATENCY - 1);
                end
                S_MEMADR: r_state <= (instOpcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  r_state <= memReady ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= memReady ? S_FETCH : S_MEMWR;
                S_REXEC:  r_state <= S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                S_MULT: begin
                    r_state <= (r_cnt == '0) ? S_FETCH : S_MULT;
                    r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Only irWrite/pcWrite in FETCH look at memReady; everything else is a pure function of state.
    always_comb begin
        pcWrite = 1'b0; pcWriteCond = 1'b0; branchNe = 1'b0; IorD = 1'b0;
        memRead = 1'b0; memWrite = 1'b0; irWrite = 1'b0; regWrite = 1'b0;
        memToReg = 1'b0; link = 1'b0; ALUSrcA = 1'b0; regDst = 2'b00;
        ALUSrcB = 2'b00; ALUOp = 2'b00; pcSrc = 2'b00; regWriteDataSrc = 2'b00;
        multStart = 1'b0; multLoad = 1'b0; illegalInst = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    memRead = 1'b1; ALUSrcB = 2'b01;
                    irWrite = memReady; pcWrite = memReady;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11; illegalInst = ~w_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10;
                end
                S_MEMRD:  begin IorD = 1'b1; memRead = 1'b1; end
                S_MEMWB:  begin regWrite = 1'b1; memToReg = 1'b1; end
                S_MEMWR:  begin IorD = 1'b1; memWrite = 1'b1; end
                S_REXEC:  begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
                S_RWB:    begin regWrite = 1'b1; regDst = 2'b01; end
                S_IEXEC: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b11;
                end
                S_IWB:    regWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = 1'b1; ALUOp = 2'b01; pcWriteCond = 1'b1; pcSrc = 2'b01;
                    branchNe = (instOpcode == OP_BNE);
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSrc    = (instOpcode == OP_R) ? 2'b11 : 2'b10;
                    regWrite = w_jal; link = w_jal;
                    regDst   = w_jal ? 2'b10 : 2'b00;
                end
                S_MULT: begin
                    multStart = (r_cnt == CNT_W'(MULT_LATENCY - 1));
                    multLoad  = (r_cnt == '0);
                end
                S_HILOWB: begin
                    regWrite = 1'b1; regDst = 2'b01;
                    regWriteDataSrc = (instFunc == F_MFHI) ? 2'b10 : 2'b01;
                end
                S_LUIWB: begin
                    regWrite = 1'b1; regWriteDataSrc = 2'b11;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of state and all control outputs.
module tb_multicycle_controller;
    localparam logic [23:0] PW = 24'h1 << 23, PWC = 24'h1 << 22, BNE_ = 24'h1 << 21, IOD = 24'h1 << 20;
    localparam logic [23:0] MRD = 24'h1 << 19, MWR = 24'h1 << 18, IRW = 24'h1 << 17, RW = 24'h1 << 16;
    localparam logic [23:0] M2R = 24'h1 << 15, LNK = 24'h1 << 14, SA = 24'h1 << 13;
    localparam logic [23:0] RD1 = 24'h1 << 11, RD2 = 24'h2 << 11;
    localparam logic [23:0] SB1 = 24'h1 << 9, SB2 = 24'h2 << 9, SB3 = 24'h3 << 9;
    localparam logic [23:0] OP1 = 24'h1 << 7, OP2 = 24'h2 << 7, OP3 = 24'h3 << 7;
    localparam logic [23:0] PS1 = 24'h1 << 5, PS2 = 24'h2 << 5, PS3 = 24'h3 << 5;
    localparam logic [23:0] WS1 = 24'h1 << 3, WS2 = 24'h2 << 3, WS3 = 24'h3 << 3;
    localparam logic [23:0] MS = 24'h4, ML = 24'h2, ILL = 24'h1;
    localparam logic [23:0] F1 = PW | IRW | MRD | SB1, F0 = MRD | SB1, DEC = SB3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, memReady, rst2, memReady2;
    logic [5:0] op, func, op2, func2;
    logic pcWrite, pcWriteCond, branchNe, IorD, memRead, memWrite, irWrite, regWrite, memToReg, link, ALUSrcA;
    logic [1:0] regDst, ALUSrcB, ALUOp, pcSrc, rwds;
    logic multStart, multLoad, illegalInst;
    logic [3:0] state;
    logic pcWrite2, pcWriteCond2, branchNe2, IorD2, memRead2, memWrite2, irWrite2, regWrite2, memToReg2, link2, ALUSrcA2;
    logic [1:0] regDst2, ALUSrcB2, ALUOp2, pcSrc2, rwds2;
    logic multStart2, multLoad2, illegalInst2;
    logic [3:0] state2;
    logic [23:0] o1, o2;
    int checks = 0, failures = 0;

    assign o1 = {pcWrite, pcWriteCond, branchNe, IorD, memRead, memWrite, irWrite, regWrite, memToReg, link,
                 ALUSrcA, regDst, ALUSrcB, ALUOp, pcSrc, rwds, multStart, multLoad, illegalInst};
    assign o2 = {pcWrite2, pcWriteCond2, branchNe2, IorD2, memRead2, memWrite2, irWrite2, regWrite2, memToReg2, link2,
                 ALUSrcA2, regDst2, ALUSrcB2, ALUOp2, pcSrc2, rwds2, multStart2, multLoad2, illegalInst2};

    multicycle_controller #(.MULT_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .instOpcode(op), .instFunc(func), .zero(1'b0), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe), .IorD(IorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .memToReg(memToReg), .link(link),
        .ALUSrcA(ALUSrcA), .regDst(regDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .pcSrc(pcSrc),
        .regWriteDataSrc(rwds), .multStart(multStart), .multLoad(multLoad), .illegalInst(illegalInst),
        .state(state));

    multicycle_controller #(.MULT_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst2), .instOpcode(op2), .instFunc(func2), .zero(1'b0), .memReady(memReady2),
        .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .branchNe(branchNe2), .IorD(IorD2), .memRead(memRead2),
        .memWrite(memWrite2), .irWrite(irWrite2), .regWrite(regWrite2), .memToReg(memToReg2), .link(link2),
        .ALUSrcA(ALUSrcA2), .regDst(regDst2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .pcSrc(pcSrc2),
        .regWriteDataSrc(rwds2), .multStart(multStart2), .multLoad(multLoad2), .illegalInst(illegalInst2),
        .state(state2));

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [23:0] o);
        #1;
        chk({tag, "_st"}, {20'd0, state}, {20'd0, st});
        chk({tag, "_out"}, o1, o);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input string tag, input logic [3:0] st, input logic [23:0] o);
        #1;
        chk({tag, "_st"}, {20'd0, state2}, {20'd0, st});
        chk({tag, "_out"}, o2, o);
        @(posedge clk);
        #1;
    endtask

    task automatic prologue(input logic [5:0] o, input logic [5:0] f);
        op = o; func = f; memReady = 1'b1;
        cyc("fetch", 4'd0, F1);
        cyc("decode", 4'd1, DEC);
    endtask

    initial begin
        rst = 1'b1; memReady = 1'b1; op = 6'b000000; func = 6'b100000;
        rst2 = 1'b1; memReady2 = 1'b1; op2 = 6'b000000; func2 = 6'b011000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        prologue(6'b000000, 6'b100000);
        cyc("add_exec", 4'd6, SA | OP2);
        cyc("add_wb", 4'd7, RW | RD1);
        prologue(6'b000000, 6'b100000);
        rst = 1'b1;
        cyc("rst_0", 4'd0, 24'h0);
        cyc("rst_1", 4'd0, 24'h0);
        cyc("rst_2", 4'd0, 24'h0);
        rst = 1'b0; memReady = 1'b0;
        cyc("rel_fetch_wait", 4'd0, F0);
        prologue(6'b100011, 6'b000000);
        cyc("lw_adr", 4'd2, SA | SB2);
        memReady = 1'b0;
        cyc("lw_rd0", 4'd3, IOD | MRD);
        cyc("lw_rd1", 4'd3, IOD | MRD);
        memReady = 1'b1;
        cyc("lw_rd2", 4'd3, IOD | MRD);
        cyc("lw_wb", 4'd4, RW | M2R);
        prologue(6'b101011, 6'b000000);
        cyc("sw_adr", 4'd2, SA | SB2);
        memReady = 1'b0;
        cyc("sw_wr0", 4'd5, IOD | MWR);
        memReady = 1'b1;
        cyc("sw_wr1", 4'd5, IOD | MWR);
        prologue(6'b001101, 6'b000000);
        cyc("ori_exec", 4'd8, SA | SB2 | OP3);
        cyc("ori_wb", 4'd9, RW);
        prologue(6'b000100, 6'b000000);
        cyc("beq", 4'd10, SA | OP1 | PWC | PS1);
        prologue(6'b000101, 6'b000000);
        cyc("bne", 4'd10, SA | OP1 | PWC | PS1 | BNE_);
        prologue(6'b000010, 6'b000000);
        cyc("j", 4'd11, PW | PS2);
        prologue(6'b000011, 6'b000000);
        cyc("jal", 4'd11, PW | PS2 | RW | RD2 | LNK);
        prologue(6'b000000, 6'b001000);
        cyc("jr", 4'd11, PW | PS3);
        prologue(6'b000000, 6'b010010);
        cyc("mflo", 4'd13, RW | RD1 | WS1);
        prologue(6'b000000, 6'b010000);
        cyc("mfhi", 4'd13, RW | RD1 | WS2);
        prologue(6'b001111, 6'b000000);
        cyc("lui", 4'd14, RW | WS3);
        prologue(6'b000000, 6'b011000);
        cyc("mult_1", 4'd12, MS);
        cyc("mult_2", 4'd12, 24'h0);
        cyc("mult_3", 4'd12, 24'h0);
        cyc("mult_4", 4'd12, ML);
        op = 6'b111111; func = 6'b000000;
        cyc("ill_fetch", 4'd0, F1);
        cyc("ill_dec", 4'd1, DEC | ILL);
        op = 6'b000000; func = 6'b111111;
        cyc("illf_fetch", 4'd0, F1);
        cyc("illf_dec", 4'd1, DEC | ILL);
        prologue(6'b000000, 6'b011000);
        cyc("mrst_1", 4'd12, MS);
        cyc("mrst_2", 4'd12, 24'h0);
        rst = 1'b1;
        cyc("mrst_r0", 4'd0, 24'h0);
        cyc("mrst_r1", 4'd0, 24'h0);
        cyc("mrst_r2", 4'd0, 24'h0);
        rst = 1'b0;
        cyc("mrst_fetch", 4'd0, F1);
        rst = 1'b1;
        rst2 = 1'b0;
        cyc2("m1_fetch", 4'd0, F1);
        cyc2("m1_dec", 4'd1, DEC);
        cyc2("m1_mult", 4'd12, MS | ML);
        memReady2 = 1'b0;
        cyc2("m1_after", 4'd0, F0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle MIPS control unit: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back states. Replaces the single-cycle decoder so one ALU and one memory port are shared across cycles. Adds a variable-latency memory handshake and a parametrised iterative-multiply wait. Sits between the instruction register (IR) and the datapath muxes, register-file write enables and PC write logic.

## Interface
- MULT_LATENCY, 4: cycles the iterative multiplier needs, ≥1.
- CNT_W, $clog2(MULT_LATENCY+1): width of the multiply counter (derived).

- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- instOpcode  in  6  IR[31:26]; stable from DECODE onward.
- instFunc  in  6  IR[5:0].
- zero  in  1  ALU zero flag. Not used inside the FSM; gating is done by downstream PC logic.
- memReady  in  1  memory done/accept this cycle.
- pcWrite, pcWriteCond, branchNe  out  1 each  unconditional PC write; conditional PC write; invert the zero test (BNE).
- IorD, memRead, memWrite, irWrite  out  1 each  memory address = ALUOut; read request; write request; IR load.
- regWrite, memToReg, link, ALUSrcA  out  1 each.
- regDst, ALUSrcB, ALUOp, pcSrc, regWriteDataSrc  out  2 each.
  - ALUOp encoding: 00 = add, 01 = sub, 10 = funct, 11 = immediate-op.
  - pcSrc encoding: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs.
  - regWriteDataSrc encoding: 00 = ALU/mem, 01 = LO, 10 = HI, 11 = LUI.
- multStart, multLoad  out  1 each  start the multiplier; latch HI/LO.
- illegalInst  out  1  one-cycle pulse on an undecoded instruction.
- state  out  4  current state, for debug.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - REXEC 6, RWB 7, IEXEC 8, IWB 9
  - BRANCH 10, JUMP 11, MULT 12, HILOWB 13, LUIWB 14
- All outputs default to 0 and are driven only in the states listed below.
- FETCH:
  - Drive memRead=1, ALUSrcB=01 (+4), ALUOp=00.
  - irWrite=1 and pcWrite=1 only in the cycle memReady=1; that cycle the FSM moves to DECODE.
  - While memReady=0, stay in FETCH.
- DECODE:
  - Drive ALUSrcB=11 (branch offset), ALUOp=00.
  - Dispatch by opcode:
    - LW/SW → MEMADR
    - R-type ADD/SUB/AND/OR/SLT → REXEC
    - R-type MULT → MULT; load cnt=MULT_LATENCY-1
    - R-type MFLO/MFHI → HILOWB
    - R-type JR → JUMP
    - ADDI/ANDI/ORI → IEXEC
    - BEQ/BNE → BRANCH
    - J/JAL → JUMP
    - LUI → LUIWB
    - anything else → FETCH, with illegalInst=1 for that cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: IorD=1, memRead=1; hold until memReady, then go to MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=00; then FETCH.
- MEMWR: IorD=1, memWrite=1; hold until memReady, then FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then RWB.
- RWB: regWrite=1, regDst=01; then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11; then IWB.
- IWB: regWrite=1, regDst=00; then FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, pcWriteCond=1, pcSrc=01, branchNe=(opcode==BNE); then FETCH.
- JUMP: pcWrite=1; then FETCH.
  - J: pcSrc=10.
  - JAL: pcSrc=10, plus regWrite=1, regDst=10, link=1.
  - JR: pcSrc=11.
- MULT:
  - multStart=1 in the first MULT cycle only.
  - cnt decrements each cycle; when cnt==0, multLoad=1 and the next state is FETCH.
  - Occupancy is exactly MULT_LATENCY cycles.
- HILOWB: regWrite=1, regDst=01, regWriteDataSrc=01 (MFLO) or 10 (MFHI); then FETCH.
- LUIWB: regWrite=1, regDst=00, regWriteDataSrc=11; then FETCH.

## Timing
- rst=1 at a rising edge: state←FETCH, cnt←0.
- While rst=1, all outputs are forced to 0 (including memRead and illegalInst) and state=0.
- Reset mid-instruction (e.g. in MEMWR or MULT) aborts it: no further writes, multLoad is not pulsed, and fetch restarts on the first cycle after rst falls.
- Latency with memReady held 1 (FETCH = 1 cycle):
  - 3 cycles: BEQ/BNE, J/JAL/JR, MFLO/MFHI, LUI
  - 4 cycles: R-type ALU, immediate ops, SW
  - 5 cycles: LW
  - 2+MULT_LATENCY cycles: MULT
- Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- memRead/memWrite stay asserted continuously until the memReady cycle, then deassert next cycle.
- irWrite/pcWrite in FETCH are coincident with memReady (Mealy); all other outputs are Moore.
- MULT_LATENCY=1: MULT is a single cycle with multStart=1 and multLoad=1 together.

## Test plan
- Reset: hold rst 3 cycles in state REXEC → state=0 and all outputs 0 during rst; memRead=1 on the first cycle after release.
- R-type ADD with memReady=1: states 0,1,6,7, then 0; regWrite=1 with regDst=01 only in cycle 4.
- LW with memReady low 2 cycles in MEMRD: states 0,1,2,3,3,3,4; memRead continuous through the MEMRD cycles; regWrite+memToReg once.
- MULT with MULT_LATENCY=4: multStart pulses in the first MULT cycle, multLoad in the 4th, no regWrite; total 6 cycles. Repeat with MULT_LATENCY=1 → 3 cycles.
- BNE: pcWriteCond=1, branchNe=1, ALUOp=01 in cycle 3. JAL: pcWrite=1, pcSrc=10, regDst=10, link=1, regWrite=1 in cycle 3.
- Opcode 6'b111111: illegalInst=1 for exactly 1 cycle in DECODE; no regWrite/memWrite/pcWrite; next state FETCH.
